alu_mdu_seq: RTL and testbench
==============================

Name: alu_mdu_seq

Overview:
- Parametrised, handshaked execute unit for the RV32IM core: RV32I ALU ops (single-cycle, registered) plus M-extension multiply/divide/remainder using a shared iterative datapath (one bit per cycle).
- Sits in EX stage. Decode drives operands/op via valid/ready; writeback consumes result via valid/ready, allowing stalls while MUL/DIV iterate.

Parameters:
- WIDTH, 32, datapath width in bits (power of two, >=8); shift amount uses low $clog2(WIDTH) bits of op_b.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous abort of in-flight or pending op (pipeline kill).
- in_valid  input  1  op_a/op_b/alu_ctrl valid.
- in_ready  output  1  unit can accept an op this cycle.
- op_a  input  WIDTH  operand A (rs1).
- op_b  input  WIDTH  operand B (rs2/imm).
- alu_ctrl  input  5  operation select.
- out_valid  output  1  result/zero valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- busy  output  1  high in MUL or DIV state.

Behaviour:
- alu_ctrl codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18-31 -> result 0, single-cycle.
- FSM states: IDLE, MUL, DIV, DONE. Reset (rst_n=0 at edge): state IDLE, out_valid=0, result=0, zero=0 (registered), busy=0, iteration counter=0. in_ready=1 after reset.
- in_ready = (state==IDLE). Accept = in_valid & in_ready at an edge; operands/op are latched at acceptance, inputs are don't-care afterwards.
- Base ops (0-9, 18-31): computed at acceptance edge, state -> DONE; out_valid high the next cycle (latency 1).
- MUL ops: operands converted to magnitudes with sign per op (MULH signed x signed, MULHSU signed x unsigned, MULHU/MUL unsigned treatment with sign fix). 2*WIDTH-bit shift-add product over exactly WIDTH cycles in MUL, then sign correction and select low (MUL) or high (MULH*) half, state -> DONE. out_valid first high WIDTH+1 cycles after acceptance.
- DIV ops: restoring divider over magnitudes, WIDTH cycles in DIV, then quotient/remainder sign fix (quotient negative if signs differ; remainder takes dividend sign), out_valid WIDTH+1 cycles after acceptance.
- Special cases, latency 1, no iteration: divisor 0 -> DIV/DIVU quotient all-ones, REM/REMU remainder = op_a. Signed overflow (op_a = 1 followed by zeros, op_b = all-ones) -> DIV quotient = op_a, REM = 0.
- DONE: result/out_valid held stable until out_ready. out_valid & out_ready -> IDLE, out_valid=0 next cycle. No new op accepted in the handshake cycle (in_ready low in DONE); throughput: one op per latency+1 cycles minimum.
- zero always equals (result == 0) for the held result.
- flush=1 at an edge: state -> IDLE, out_valid -> 0, counter cleared, result retained but invalid. Any in_valid in that cycle is ignored. rst_n has priority over flush.
- Reset mid-iteration aborts identically to flush, plus clears result/zero.
- All arithmetic is modulo 2^WIDTH. Shifts use op_b[$clog2(WIDTH)-1:0]. SRA replicates op_a MSB.

Test Plan:
- Reset/base: rst_n low 2 cycles, then ADD 5+7, out_ready=1 -> out_valid 1 cycle later, result=12, zero=0; SUB 3-3 -> result 0, zero=1; SRA 0x80000000 by 4 -> 0xF8000000.
- Multiply: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 at cycle 33; MULHU same -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF; MUL 0x10000 x 0x10000 -> 0; busy high cycles 1-32.
- Divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; all at latency 33.
- Corners: DIV x/0 -> 0xFFFFFFFF and REMU 9/0 -> 9, latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Backpressure: out_ready=0 for 10 cycles after DIV completes -> result/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, next op accepted.
- Abort: flush at iteration 10 of MUL -> out_valid never asserts, in_ready=1 next cycle; repeat with rst_n low mid-DIV -> result=0, zero=0.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// RV32IM execute unit: single-cycle ALU ops plus iterative one-bit-per-cycle multiply/divide.
// Decode hands ops in over in_valid/in_ready; writeback drains results over out_valid/out_ready.
//
// state | meaning
// IDLE  | ready to accept an op
// MUL   | shift-add multiply iterating, one multiplier bit per cycle
// DIV   | restoring divide iterating, one quotient bit per cycle
// DONE  | result held until the consumer takes it
module alu_mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [4:0]       i_alu_ctrl,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0]   CNT_ONE  = SHW'(1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SLTU   = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state;
  logic [SHW-1:0]     r_cnt;
  logic [4:0]         r_op;
  logic               r_qneg;
  logic               r_rneg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_out_valid;

  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_alu;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_div_special;
  logic [WIDTH-1:0]   w_fast_res;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_mul_res;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_div_res;

  assign w_shamt = i_op_b[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (i_alu_ctrl)
      OP_ADD:  w_alu = i_op_a + i_op_b;
      OP_SUB:  w_alu = i_op_a - i_op_b;
      OP_AND:  w_alu = i_op_a & i_op_b;
      OP_OR:   w_alu = i_op_a | i_op_b;
      OP_XOR:  w_alu = i_op_a ^ i_op_b;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (i_op_a < i_op_b)};
      OP_SLL:  w_alu = i_op_a << w_shamt;
      OP_SRL:  w_alu = i_op_a >> w_shamt;
      OP_SRA:  w_alu = $signed(i_op_a) >>> w_shamt;
      default: w_alu = '0;
    endcase
  end

  // Low half of a product is sign-agnostic, so MUL runs unsigned like MULHU.
  always_comb begin
    w_is_mul   = (i_alu_ctrl >= OP_MUL) && (i_alu_ctrl <= OP_MULHU);
    w_is_div   = (i_alu_ctrl >= OP_DIV) && (i_alu_ctrl <= OP_REMU);
    w_a_signed = (i_alu_ctrl == OP_MULH) || (i_alu_ctrl == OP_MULHSU) ||
                 (i_alu_ctrl == OP_DIV)  || (i_alu_ctrl == OP_REM);
    w_b_signed = (i_alu_ctrl == OP_MULH) || (i_alu_ctrl == OP_DIV) ||
                 (i_alu_ctrl == OP_REM);
    w_sa       = w_a_signed & i_op_a[WIDTH-1];
    w_sb       = w_b_signed & i_op_b[WIDTH-1];
    w_mag_a    = w_sa ? -i_op_a : i_op_a;
    w_mag_b    = w_sb ? -i_op_b : i_op_b;
    w_div_special = w_is_div && ((i_op_b == '0) ||
                    (w_a_signed && (i_op_a == MIN_NEG) && (i_op_b == '1)));
    w_fast_res = w_alu;
    if (i_alu_ctrl == OP_DIV || i_alu_ctrl == OP_DIVU)
      w_fast_res = (i_op_b == '0) ? '1 : i_op_a;
    else if (i_alu_ctrl == OP_REM || i_alu_ctrl == OP_REMU)
      w_fast_res = (i_op_b == '0) ? i_op_a : '0;
  end

  // {r_hi, r_lo} holds partial product over remaining multiplier bits, shifting right.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_mul_hi  = w_mul_sum[WIDTH:1];
    w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    w_prod    = r_qneg ? -{w_mul_hi, w_mul_lo} : {w_mul_hi, w_mul_lo};
    w_mul_res = (r_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
  end

  // r_hi is the partial remainder, r_lo shifts the dividend out and quotient bits in.
  always_comb begin
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    w_div_rem   = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_opnd) : w_div_shift[WIDTH-1:0];
    w_div_quo   = {r_lo[WIDTH-2:0], w_div_ge};
    if (r_op == OP_DIV || r_op == OP_DIVU)
      w_div_res = r_qneg ? -w_div_quo : w_div_quo;
    else
      w_div_res = r_rneg ? -w_div_rem : w_div_rem;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (i_flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_op   <= i_alu_ctrl;
            r_qneg <= w_sa ^ w_sb;
            r_rneg <= w_sa;
            if (w_is_mul) begin
              r_hi    <= '0;
              r_lo    <= w_mag_b;
              r_opnd  <= w_mag_a;
              r_cnt   <= CNT_LAST;
              r_state <= S_MUL;
            end else if (w_is_div && !w_div_special) begin
              r_hi    <= '0;
              r_lo    <= w_mag_a;
              r_opnd  <= w_mag_b;
              r_cnt   <= CNT_LAST;
              r_state <= S_DIV;
            end else begin
              r_result    <= w_fast_res;
              r_zero      <= (w_fast_res == '0);
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_hi <= w_mul_hi;
          r_lo <= w_mul_lo;
          if (r_cnt == '0) begin
            r_result    <= w_mul_res;
            r_zero      <= (w_mul_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_DIV: begin
          r_hi <= w_div_rem;
          r_lo <= w_div_quo;
          if (r_cnt == '0) begin
            r_result    <= w_div_res;
            r_zero      <= (w_div_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_zero      = r_zero;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: expected results are queued at issue and
// checked by an independent monitor when the unit hands a result over.
module tb_alu_mdu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [W-1:0] op_a, op_b, result;
  logic [4:0]   alu_ctrl;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  exp_t sbq[$];
  bit   seen = 1'b0;
  int   first_cyc = 0;

  alu_mdu_seq #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_op_a(op_a), .i_op_b(op_b), .i_alu_ctrl(alu_ctrl),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_result(result), .o_zero(zero), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, between driver updates and the next active edge.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !seen) begin
      seen = 1'b1;
      first_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected out_valid", W'(out_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        check({e.name, " result"}, result, e.res);
        check({e.name, " zero"}, W'(zero), W'(e.res == '0));
        check({e.name, " latency"}, W'(first_cyc - e.acc + 1), W'(e.lat));
      end
      seen = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat, input string name,
                       input bit expect_out);
    exp_t e;
    int g = 0;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    if (!in_ready) begin
      check({name, " in_ready timeout"}, W'(in_ready), 32'd1);
      return;
    end
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    if (expect_out) begin
      e.res  = exp;
      e.lat  = lat;
      e.acc  = cyc + 1;
      e.name = name;
      sbq.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctrl = 5'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while ((sbq.size() != 0 || !in_ready) && g < 200) begin
      tick();
      g++;
    end
    check({name, " drain pending"}, W'(sbq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw;
    int g;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    op_a = 32'h1234; op_b = 32'h5678; alu_ctrl = 5'd0;
    tick();
    tick();
    in_valid = 1'b0;
    check("reset in_ready",  W'(in_ready),  32'd1);
    check("reset out_valid", W'(out_valid), 32'd0);
    check("reset result",    result,        32'd0);
    check("reset zero",      W'(zero),      32'd0);
    check("reset busy",      W'(busy),      32'd0);
    rst_n = 1'b1;
    tick();

    issue(5'd0, 32'd5, 32'd7, 32'd12, 1, "ADD", 1);
    issue(5'd1, 32'd3, 32'd3, 32'd0, 1, "SUB", 1);
    issue(5'd9, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, "SRA", 1);
    issue(5'd8, 32'h8000_0000, 32'd36, 32'h0800_0000, 1, "SRL", 1);
    issue(5'd7, 32'd1, 32'h0000_003F, 32'h8000_0000, 1, "SLL", 1);
    issue(5'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, "SLT", 1);
    issue(5'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "SLTU", 1);
    issue(5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, "AND", 1);
    issue(5'd3, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1, "OR", 1);
    issue(5'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, "XOR", 1);
    issue(5'd20, 32'd9, 32'd9, 32'd0, 1, "CTRL20", 1);
    wait_idle("base");

    issue(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33, "MULH", 1);
    for (int i = 1; i <= 32; i++) begin
      check($sformatf("MULH busy cycle %0d", i), W'(busy), 32'd1);
      tick();
    end
    check("MULH busy cleared", W'(busy), 32'd0);
    issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU", 1);
    issue(5'd12, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, "MULHSU", 1);
    issue(5'd10, 32'h0001_0000, 32'h0001_0000, 32'd0, 33, "MUL", 1);
    issue(5'd10, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL neg", 1);
    wait_idle("mul");

    issue(5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV", 1);
    issue(5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM", 1);
    issue(5'd14, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIV by0", 1);
    issue(5'd17, 32'd9, 32'd0, 32'd9, 1, "REMU by0", 1);
    issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf", 1);
    issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "REM ovf", 1);
    issue(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "DIVU big", 1);
    wait_idle("div");

    out_ready = 1'b0;
    issue(5'd15, 32'd100, 32'd7, 32'd14, 33, "DIVU", 1);
    g = 0;
    while (!out_valid && g < 100) begin
      tick();
      g++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid held", W'(out_valid), 32'd1);
      check("bp result held", result, 32'd14);
      check("bp in_ready low", W'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp idle after handshake", W'(in_ready), 32'd1);
    check("bp out_valid dropped", W'(out_valid), 32'd0);
    issue(5'd17, 32'd100, 32'd7, 32'd2, 33, "REMU", 1);
    wait_idle("bp");

    issue(5'd13, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0, "MULHU flushed", 0);
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    in_valid = 1'b1; alu_ctrl = 5'd0; op_a = 32'd1; op_b = 32'd1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush in_ready", W'(in_ready), 32'd1);
    check("flush out_valid", W'(out_valid), 32'd0);
    check("flush busy", W'(busy), 32'd0);
    check("flush result retained", result, 32'd2);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) saw = 1'b1;
      tick();
    end
    check("flush no out_valid", W'(saw), 32'd0);

    issue(5'd14, 32'd1000, 32'd3, 32'd0, 0, "DIV reset", 0);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset result", result, 32'd0);
    check("midreset zero", W'(zero), 32'd0);
    check("midreset out_valid", W'(out_valid), 32'd0);
    check("midreset in_ready", W'(in_ready), 32'd1);
    check("midreset busy", W'(busy), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) saw = 1'b1;
      tick();
    end
    check("midreset no out_valid", W'(saw), 32'd0);

    issue(5'd0, 32'd1, 32'd1, 32'd2, 1, "ADD after reset", 1);
    wait_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
